slave_rd_data_ctrl: RTL
=======================

SLAVE_RD_DATA_CTRL -- requirements
Module: slave_rd_data_ctrl

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, width of AR/R ID fields.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, R data width (power of 2, 8..1024).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, R beat buffer entries (power of 2, 2..64).
REQ-005 SHALL have the following ports, in this order:
- clk, in, 1: single clock; all logic on rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- s_arid, in, ID_WIDTH: AR ID.
- s_araddr, in, ADDR_WIDTH: AR start address.
- s_arlen, in, 8: AR beats minus 1.
- s_arsize, in, 3: AR log2 bytes per beat.
- s_arburst, in, 2: AR burst type.
- s_arvalid, in, 1: AR valid.
- s_arready, out, 1: AR ready.
- s_rid, out, ID_WIDTH: R ID.
- s_rdata, out, DATA_WIDTH: R data.
- s_rresp, out, 2: R response.
- s_rlast, out, 1: R last beat.
- s_rvalid, out, 1: R valid.
- s_rready, in, 1: R ready.
- mem_rd_en, out, 1: local memory read strobe.
- mem_rd_addr, out, ADDR_WIDTH: local memory read address.
- mem_rd_data, in, DATA_WIDTH: read data, valid exactly 1 cycle after mem_rd_en.

Function
REQ-006 SHALL implement FSM states IDLE and BURST; s_arready SHALL be 1 only in IDLE.
REQ-007 In IDLE, s_arvalid=1 SHALL latch id/addr/len/size/burst, load beat counter = s_arlen, and move to BURST.
REQ-008 In BURST, SHALL assert mem_rd_en when (fifo_count + inflight - pop_this_cycle) < FIFO_DEPTH; inflight = mem_rd_en of previous cycle.
REQ-009 Address update per issued beat:
- FIXED (2'b00): address unchanged.
- INCR (2'b01): address += 1<<size, ADDR_WIDTH wrap-around.
- WRAP (2'b10): address += 1<<size within an aligned window of (len+1)<<size bytes; the low bits wrap.
REQ-010 Error conditions SHALL set rresp=SLVERR (2'b10) for every beat of the burst, suppress mem_rd_en, and push beats with rdata=0 at the same pacing:
- burst 2'b11;
- s_arsize > log2(DATA_WIDTH/8);
- WRAP with len not in {1,3,7,15}.
REQ-011 Otherwise rresp SHALL be OKAY (2'b00).
REQ-012 On the cycle the last beat is issued (counter==0), the FSM SHALL return to IDLE; the next AR may be accepted the following cycle.
REQ-013 Each beat SHALL be pushed into the FIFO one cycle after issue, as {id, mem_rd_data, resp, last}; last=1 only on the final beat.
REQ-014 s_rvalid SHALL equal FIFO non-empty; a pop occurs on s_rvalid & s_rready; R fields SHALL hold stable while s_rvalid=1 and s_rready=0.
REQ-015 Latency: AR handshake at cycle N -> mem_rd_en at N+1 -> FIFO write at N+2 -> s_rvalid at N+3.
REQ-016 With s_rready held at 1, throughput SHALL be 1 beat/cycle, including across back-to-back bursts, apart from the 1-cycle IDLE slot.
REQ-017 The FIFO SHALL never overflow; a push and a pop in the same cycle at full SHALL both succeed.
REQ-018 R beats SHALL be returned in AR order; no interleaving.

Reset
REQ-019 While rst=1, SHALL hold: FSM=IDLE; counters, FIFO pointers and count = 0; s_arready=1; mem_rd_en=0; s_rvalid=0; s_rlast=0; s_rresp=0; s_rid=0; s_rdata=0; mem_rd_addr=0.
REQ-020 Reset mid-burst SHALL discard all buffered and in-flight beats; no R beat from that burst SHALL appear after release.

Structure
REQ-021 Burst encodings (FIXED/INCR/WRAP) and resp codes (OKAY/SLVERR) SHALL live in the shared AXI package.
REQ-022 The beat buffer SHALL be the sub-module slave_rd_data_fifo: single-clock, width ID_WIDTH+DATA_WIDTH+3, depth FIFO_DEPTH, with count output.

Verification
REQ-023 INCR: addr=0x100, len=3, size=2, rready=1 -> mem_rd_addr 0x100/0x104/0x108/0x10C on consecutive cycles; 4 R beats, rlast on the 4th, rresp=0.
REQ-024 WRAP: addr=0x38, len=3, size=2 -> addresses 0x38, 0x3C, 0x30, 0x34.
REQ-025 Backpressure: INCR len=15 with rready=0 for 20 cycles -> exactly FIFO_DEPTH reads issued, then stall; data arrives in order with no loss after rready=1.
REQ-026 Error: arburst=2'b11, len=1 -> no mem_rd_en; 2 beats with rresp=2'b10, rdata=0, rlast on the 2nd.
REQ-027 Back-to-back: two AR (id 1 len 0, id 2 len 1) presented continuously -> R id sequence 1,2,2; rlast on beats 1 and 3.
REQ-028 Reset: assert rst during beat 2 of a len=7 burst -> after release, s_rvalid=0 and s_arready=1 until a new AR arrives.

Source files
------------

// File: rtl/slave_rd_data_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// slave_rd_data_ctrl_pkg
//
// Shared AXI definitions for the slave read-data path: burst encodings,
// response codes, the read-controller FSM state type and a helper that
// classifies an incoming AR request as legal or not.
// -----------------------------------------------------------------------------
package slave_rd_data_ctrl_pkg;

    // AXI burst type encodings (ARBURST)
    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } axi_burst_e;

    // AXI response encodings (RRESP)
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Read controller FSM states
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // An AR request is answered with SLVERR on every beat when the burst type
    // is reserved, the beat size exceeds the data bus, or a WRAP length is
    // not one of the legal values.
    function automatic logic ar_is_error(
        input logic [1:0] burst,
        input logic [2:0] size,
        input logic [7:0] len,
        input logic [2:0] max_size
    );
        logic err;
        err = 1'b0;
        if (burst == BURST_RSVD)
            err = 1'b1;
        if (size > max_size)
            err = 1'b1;
        if ((burst == BURST_WRAP) && !wrap_len_legal(len))
            err = 1'b1;
        return err;
    endfunction

endpackage

// File: rtl/slave_rd_data_fifo.sv
// -----------------------------------------------------------------------------
// slave_rd_data_fifo
//
// Single-clock show-ahead FIFO holding R beats between the memory read
// pipeline and the AXI R channel. The head entry is presented combinationally
// on rd_data whenever the FIFO is non-empty; when empty rd_data reads as zero
// so that downstream R fields are quiet between bursts and during reset.
// A write and a read in the same cycle while full both take effect.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset (clears pointers and count)
//   wr_en    - push wr_data
//   wr_data  - entry to push
//   rd_en    - pop the head entry (ignored when empty)
//   rd_data  - head entry (zero when empty)
//   empty    - no entries stored
//   count    - number of entries stored (0..DEPTH)
// -----------------------------------------------------------------------------
module slave_rd_data_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic full;
    logic do_rd;
    logic do_wr;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == DEPTH_C);
    assign count = count_reg;

    // A pop frees the slot being written, so a push at full is accepted
    // whenever a pop happens in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Storage array: no reset, so it maps onto plain RAM/registers.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem_reg[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_rd)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            unique case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rd_data = empty ? '0 : mem_reg[rd_ptr_reg];

endmodule

// File: rtl/slave_rd_data_ctrl.sv
// -----------------------------------------------------------------------------
// slave_rd_data_ctrl
//
// AXI slave read-data controller. Accepts one AR request at a time, walks the
// burst addresses (FIXED / INCR / WRAP), issues single-cycle read strobes to a
// local memory with a fixed 1-cycle read latency, and returns the data as R
// beats through a small beat buffer. Issue is throttled so the buffer can never
// overflow: a read is only issued when the buffer plus the read already in the
// memory pipeline leaves a free slot. Illegal requests still produce the full
// number of beats, all with SLVERR and zero data, without touching memory.
//
// Timing: AR handshake in cycle N, first read strobe in N+1, buffer write in
// N+2, s_rvalid in N+3. With s_rready high one beat per cycle is sustained,
// with a single idle cycle between bursts.
//
// Ports:
//   clk, rst                    - clock and asynchronous active-high reset
//   s_ar*                       - AXI read address channel (slave side)
//   s_r*                        - AXI read data channel (slave side)
//   mem_rd_en / mem_rd_addr     - local memory read strobe and byte address
//   mem_rd_data                 - local memory data, valid 1 cycle after strobe
// -----------------------------------------------------------------------------
module slave_rd_data_ctrl
    import slave_rd_data_ctrl_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_arid,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [7:0]            s_arlen,
    input  logic [2:0]            s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_WIDTH-1:0]   s_rid,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + 3;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    // Largest legal ARSIZE for this data bus width.
    localparam logic [2:0]     MAX_SIZE  = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Burst context and FSM state
    // ------------------------------------------------------------------
    rd_state_e             state_reg;
    logic                  arready_reg;
    logic [ID_WIDTH-1:0]   id_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [2:0]            size_reg;
    axi_burst_e            burst_reg;
    logic                  err_reg;
    logic [7:0]            cnt_reg;

    // Side information travelling alongside the read in the memory pipeline
    logic                  pipe_valid_reg;
    logic                  pipe_last_reg;
    logic                  pipe_err_reg;
    logic [ID_WIDTH-1:0]   pipe_id_reg;

    // ------------------------------------------------------------------
    // Beat buffer interface
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]    fifo_wr_data;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  r_pop;

    logic [DATA_WIDTH-1:0] push_rdata;
    axi_resp_e             push_resp;

    // ------------------------------------------------------------------
    // Issue control
    // ------------------------------------------------------------------
    logic [CNT_W:0]        occ_next;
    logic                  room;
    logic                  issue;
    logic                  ar_err;

    logic [ADDR_WIDTH-1:0] beat_bytes;
    logic [ADDR_WIDTH-1:0] wrap_bytes;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] addr_incr;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign r_pop = s_rvalid && s_rready;

    // Slots that will be taken once this cycle settles: stored beats, plus the
    // read already in the memory pipeline, minus the beat leaving on R now.
    // r_pop implies fifo_count >= 1, so this never underflows.
    assign occ_next = {1'b0, fifo_count}
                    + {{CNT_W{1'b0}}, pipe_valid_reg}
                    - {{CNT_W{1'b0}}, r_pop};
    assign room     = (occ_next < DEPTH_LIM);

    // A beat is issued whenever there is room; erroneous bursts keep the same
    // pacing but never strobe the memory.
    assign issue     = (state_reg == BURST) && room;
    assign mem_rd_en = issue && !err_reg;
    assign mem_rd_addr = addr_reg;
    assign s_arready = arready_reg;

    assign ar_err = ar_is_error(s_arburst, s_arsize, s_arlen, MAX_SIZE);

    // Address sequencing. For WRAP the window is (len+1) beats wide and
    // aligned to its own size; only the bits inside the window advance.
    assign beat_bytes = ADDR_WIDTH'(1) << size_reg;
    assign wrap_bytes = (ADDR_WIDTH'(len_reg) + ADDR_WIDTH'(1)) << size_reg;
    assign wrap_mask  = wrap_bytes - ADDR_WIDTH'(1);
    assign addr_incr  = addr_reg + beat_bytes;

    always_comb begin
        addr_next = addr_reg;
        unique case (burst_reg)
            BURST_FIXED: addr_next = addr_reg;
            BURST_INCR:  addr_next = addr_incr;
            BURST_WRAP:  addr_next = (addr_reg & ~wrap_mask) | (addr_incr & wrap_mask);
            default:     addr_next = addr_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM, burst context and memory-pipeline side information
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            arready_reg    <= 1'b1;
            id_reg         <= '0;
            addr_reg       <= '0;
            len_reg        <= '0;
            size_reg       <= '0;
            burst_reg      <= BURST_FIXED;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
            pipe_valid_reg <= 1'b0;
            pipe_last_reg  <= 1'b0;
            pipe_err_reg   <= 1'b0;
            pipe_id_reg    <= '0;
        end else begin
            // Capture everything the beat needs at issue time, because the
            // burst context may be overwritten by the next AR one cycle later.
            pipe_valid_reg <= issue;
            if (issue) begin
                pipe_last_reg <= (cnt_reg == 8'd0);
                pipe_err_reg  <= err_reg;
                pipe_id_reg   <= id_reg;
            end

            unique case (state_reg)
                IDLE: begin
                    if (s_arvalid) begin
                        id_reg      <= s_arid;
                        addr_reg    <= s_araddr;
                        len_reg     <= s_arlen;
                        size_reg    <= s_arsize;
                        burst_reg   <= axi_burst_e'(s_arburst);
                        err_reg     <= ar_err;
                        cnt_reg     <= s_arlen;
                        state_reg   <= BURST;
                        arready_reg <= 1'b0;
                    end
                end
                BURST: begin
                    if (issue) begin
                        addr_reg <= addr_next;
                        if (cnt_reg == 8'd0) begin
                            state_reg   <= IDLE;
                            arready_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    arready_reg <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Beat buffer
    // ------------------------------------------------------------------
    assign push_rdata   = pipe_err_reg ? '0 : mem_rd_data;
    assign push_resp    = pipe_err_reg ? RESP_SLVERR : RESP_OKAY;
    assign fifo_wr_data = {pipe_id_reg, push_rdata, push_resp, pipe_last_reg};

    slave_rd_data_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pipe_valid_reg),
        .wr_data (fifo_wr_data),
        .rd_en   (r_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The buffer head drives R directly, so fields are stable while stalled
    // and read as zero whenever nothing is pending.
    assign s_rvalid = !fifo_empty;
    assign {s_rid, s_rdata, s_rresp, s_rlast} = fifo_rd_data;

endmodule
